// File: rtl/cla.sv
// cla: registered carry-lookahead adder, {Cout,Sum} = A+B+Cin one cycle after sampling
//   Parameters: WIDTH - operand/sum width, multiple of 4 in 4..32
//   Ports: clk   - rising-edge clock
//          rst_n - asynchronous active-low reset, clears all outputs
//          A, B  - WIDTH-bit operands
//          Cin   - carry-in
//          Sum   - registered WIDTH-bit sum
//          Cout  - registered carry-out of the top bit
//          Ovf   - registered signed overflow, only when CLA_OVF_EN is defined
//   Configuration macro: CLA_OVF_EN
module cla #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef CLA_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int NG = WIDTH / 4;
  if (WIDTH % 4 != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("cla: WIDTH must be a multiple of 4 in 4..32");
  end
  logic [WIDTH-1:0] w_g, w_p, w_c, r_sum;
  logic [NG-1:0]    w_gg, w_gp;
  logic [NG:0]      w_gc;
  logic             w_acc, w_term, r_cout;
  assign w_g = A & B;
  assign w_p = A ^ B;
  // Intra-group carries are flat sum-of-products off the group carry-in.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int L = 4 * k;
    assign w_c[L]   = w_gc[k];
    assign w_c[L+1] = w_g[L] | w_p[L] & w_gc[k];
    assign w_c[L+2] = w_g[L+1] | w_p[L+1] & w_g[L] | w_p[L+1] & w_p[L] & w_gc[k];
    assign w_c[L+3] = w_g[L+2] | w_p[L+2] & w_g[L+1] | w_p[L+2] & w_p[L+1] & w_g[L]
                    | w_p[L+2] & w_p[L+1] & w_p[L] & w_gc[k];
    assign w_gg[k]  = w_g[L+3] | w_p[L+3] & w_g[L+2] | w_p[L+3] & w_p[L+2] & w_g[L+1]
                    | w_p[L+3] & w_p[L+2] & w_p[L+1] & w_g[L];
    assign w_gp[k]  = &w_p[L+:4];
  end
  // Second level: each group carry-in is an OR of product terms over GG/GP/Cin,
  // so no carry ripples from one group into the next.
  always_comb begin
    w_gc   = '0;
    w_acc  = 1'b0;
    w_term = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      w_acc = Cin;
      for (int j = 0; j < k; j++) w_acc = w_acc & w_gp[j];
      for (int j = 0; j < k; j++) begin
        w_term = w_gg[j];
        for (int m = j + 1; m < k; m++) w_term = w_term & w_gp[m];
        w_acc = w_acc | w_term;
      end
      w_gc[k] = w_acc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_p ^ w_c;
      r_cout <= w_gc[NG];
    end
  end
  assign Sum  = r_sum;
  assign Cout = r_cout;
`ifdef CLA_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else        r_ovf <= w_gc[NG] ^ w_c[WIDTH-1];
  end
  assign Ovf = r_ovf;
`endif
endmodule

// File: tb/tb_cla.sv
// tb_cla: table-driven and scoreboarded check of cla at WIDTH=4 and WIDTH=16
module tb_cla;
  logic        clk, rst_n;
  logic [3:0]  a4, b4, s4;
  logic [15:0] a16, b16, s16;
  logic        c4, c16, co4, co16;
`ifdef CLA_OVF_EN
  logic        o4, o16;
`endif
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] a, b;
    logic       c;
    logic [5:0] e;
  } vec_t;
  typedef struct {
    logic [5:0]  e4;
    logic [17:0] e16;
  } exp_t;
  exp_t q[$];
  vec_t tbl[4];
  cla #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(c4), .Sum(s4), .Cout(co4)
`ifdef CLA_OVF_EN
    , .Ovf(o4)
`endif
  );
  cla #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(c16), .Sum(s16), .Cout(co16)
`ifdef CLA_OVF_EN
    , .Ovf(o16)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [5:0] m4(input logic [3:0] a, b, input logic c);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b} + {4'b0, c};
    return {(a[3] == b[3]) && (t[3] != a[3]), t};
  endfunction
  function automatic logic [17:0] m16(input logic [15:0] a, b, input logic c);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + {16'b0, c};
    return {(a[15] == b[15]) && (t[15] != a[15]), t};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_sum4"}, 32'(s4), 32'd0);
    chk({n, "_cout4"}, 32'(co4), 32'd0);
    chk({n, "_sum16"}, 32'(s16), 32'd0);
    chk({n, "_cout16"}, 32'(co16), 32'd0);
`ifdef CLA_OVF_EN
    chk({n, "_ovf4"}, 32'(o4), 32'd0);
    chk({n, "_ovf16"}, 32'(o16), 32'd0);
`endif
  endtask
  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected a pending result at %0t", $time);
      return;
    end
    e = q.pop_front();
    chk("sum4", 32'(s4), 32'(e.e4[3:0]));
    chk("cout4", 32'(co4), 32'(e.e4[4]));
    chk("sum16", 32'(s16), 32'(e.e16[15:0]));
    chk("cout16", 32'(co16), 32'(e.e16[16]));
`ifdef CLA_OVF_EN
    chk("ovf4", 32'(o4), 32'(e.e4[5]));
    chk("ovf16", 32'(o16), 32'(e.e16[17]));
`endif
  endtask
  task automatic drive(input logic [3:0] a, b, input logic c, input logic [5:0] e,
                       input logic [15:0] x, y, input logic z);
    exp_t t;
    a4 = a; b4 = b; c4 = c;
    a16 = x; b16 = y; c16 = z;
    t.e4 = e;
    t.e16 = m16(x, y, z);
    q.push_back(t);
  endtask
  task automatic drive_r(input logic [3:0] a, b, input logic c, input logic [5:0] e);
    drive(a, b, c, e, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
  endtask
  initial begin
    tbl[0] = '{4'b0110, 4'b0010, 1'b0, {1'b1, 1'b0, 4'b1000}};
    tbl[1] = '{4'b0101, 4'b1101, 1'b1, {1'b0, 1'b1, 4'b0011}};
    tbl[2] = '{4'b1111, 4'b0001, 1'b0, {1'b0, 1'b1, 4'b0000}};
    tbl[3] = '{4'b1001, 4'b0011, 1'b1, {1'b0, 1'b0, 4'b1101}};
    rst_n = 1'b1;
    a4 = '0; b4 = '0; c4 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    #1 rst_n = 1'b0;
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
    #1 chk_zero("reset_noclk");
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'hF, 4'hF, 1'b1, {1'b0, 1'b1, 4'hF}, 16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_out();
      drive_r(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].e);
    end
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      check_out();
      drive_r(i[3:0], i[7:4], i[8], m4(i[3:0], i[7:4], i[8]));
    end
    @(negedge clk);
    check_out();
    drive(4'h7, 4'h1, 1'b0, m4(4'h7, 4'h1, 1'b0), 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    check_out();
    drive(4'h3, 4'h4, 1'b0, m4(4'h3, 4'h4, 1'b0), 16'h8000, 16'h8000, 1'b0);
    @(posedge clk);
    #2 a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b1;
    @(negedge clk);
    check_out();
    drive_r(4'hA, 4'h5, 1'b1, m4(4'hA, 4'h5, 1'b1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_mid");
    q.delete();
    @(posedge clk);
    #1 chk_zero("reset_mid_held");
    @(negedge clk);
    rst_n = 1'b1;
    drive_r(4'hC, 4'h3, 1'b0, m4(4'hC, 4'h3, 1'b0));
    @(negedge clk);
    check_out();
    drive_r(4'h8, 4'h8, 1'b0, m4(4'h8, 4'h8, 1'b0));
    @(negedge clk);
    check_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
